// File: rtl/apb_timeout_guard.sv
// apb_timeout_guard: APB pass-through that aborts a stalled access phase.
// While the downstream slave holds PREADY low for too long, the upstream
// transfer is completed with PSLVERR and ERR_RDATA. The downstream transfer is
// then held (DRAIN) until the slave finally responds, and that response is
// discarded.
// Optional feature macro: APB_TIMEOUT_GUARD_STATUS_EN enables the
// err_addr_o / err_cnt_o status registers. When the macro is undefined, both
// outputs are tied to zero.
module apb_timeout_guard #(
    parameter int unsigned                APB_ADDR_WIDTH = 32,
    parameter int unsigned                APB_DATA_WIDTH = 32,
    parameter int unsigned                TIMEOUT_CYCLES = 256,
    parameter logic [APB_DATA_WIDTH-1:0]  ERR_RDATA      = 32'hBADC0DE5
) (
    input  logic                      clk,
    input  logic                      rst,
    // upstream request
    input  logic [APB_ADDR_WIDTH-1:0] s_PADDR_i,
    input  logic [APB_DATA_WIDTH-1:0] s_PWDATA_i,
    input  logic                      s_PWRITE_i,
    input  logic                      s_PSEL_i,
    input  logic                      s_PENABLE_i,
    // upstream response
    output logic [APB_DATA_WIDTH-1:0] s_PRDATA_o,
    output logic                      s_PREADY_o,
    output logic                      s_PSLVERR_o,
    // downstream request
    output logic [APB_ADDR_WIDTH-1:0] m_PADDR_o,
    output logic [APB_DATA_WIDTH-1:0] m_PWDATA_o,
    output logic                      m_PWRITE_o,
    output logic                      m_PSEL_o,
    output logic                      m_PENABLE_o,
    // downstream response
    input  logic [APB_DATA_WIDTH-1:0] m_PRDATA_i,
    input  logic                      m_PREADY_i,
    input  logic                      m_PSLVERR_i,
    // status
    output logic                      timeout_irq_o,
    output logic [APB_ADDR_WIDTH-1:0] err_addr_o,
    output logic [7:0]                err_cnt_o
);

    localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_nxt;
    logic                      abort;
    logic                      abort_act;
    logic                      drain_act;
    logic [APB_ADDR_WIDTH-1:0] lat_addr;
    logic [APB_DATA_WIDTH-1:0] lat_wdata;
    logic                      lat_write;

    // State, wait counter and the latched request of an aborted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (abort) begin
                lat_addr  <= s_PADDR_i;
                lat_wdata <= s_PWDATA_i;
                lat_write <= s_PWRITE_i;
            end
        end
    end

    // Next state and counter; a real PREADY in the expiry cycle beats the abort.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (s_PSEL_i && s_PENABLE_i && !m_PREADY_i) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CW'(1);
                end
            end
            ACCESS: begin
                if (!s_PSEL_i || m_PREADY_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    abort     = 1'b1;
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (m_PREADY_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: pass-through unless aborting or draining; reset forces pass-through.
    always_comb begin
        drain_act     = (state == DRAIN) && !rst;
        abort_act     = abort && !rst;
        m_PADDR_o     = s_PADDR_i;
        m_PWDATA_o    = s_PWDATA_i;
        m_PWRITE_o    = s_PWRITE_i;
        m_PSEL_o      = s_PSEL_i;
        m_PENABLE_o   = s_PENABLE_i;
        s_PRDATA_o    = m_PRDATA_i;
        s_PREADY_o    = m_PREADY_i;
        s_PSLVERR_o   = m_PSLVERR_i;
        timeout_irq_o = abort_act;
        if (drain_act) begin
            m_PADDR_o   = lat_addr;
            m_PWDATA_o  = lat_wdata;
            m_PWRITE_o  = lat_write;
            m_PSEL_o    = 1'b1;
            m_PENABLE_o = 1'b1;
            s_PRDATA_o  = '0;
            s_PREADY_o  = 1'b0;
            s_PSLVERR_o = 1'b0;
        end else if (abort_act) begin
            s_PRDATA_o  = ERR_RDATA;
            s_PREADY_o  = 1'b1;
            s_PSLVERR_o = 1'b1;
        end
    end

`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    logic [APB_ADDR_WIDTH-1:0] err_addr_q;
    logic [7:0]                err_cnt_q;

    // Last aborted address and saturating abort count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else if (abort) begin
            err_addr_q <= s_PADDR_i;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;
`else
    assign err_addr_o = '0;
    assign err_cnt_o  = '0;
`endif

endmodule

// File: doc/apb_timeout_guard.md
APB_TIMEOUT_GUARD -- requirements
Module: apb_timeout_guard

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, range 1..65535, access-phase cycles allowed before abort.
REQ-004 SHALL have parameter ERR_RDATA, default 32'hBADC0DE5, PRDATA returned on abort.
REQ-005 SHALL have port clk, input, 1, sole clock; one clock domain; reset is synchronous and active-high.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports s_PADDR_i/s_PWDATA_i/s_PWRITE_i/s_PSEL_i/s_PENABLE_i, inputs, ADDR/DATA/1/1/1, upstream APB request from the CDC destination port.
REQ-008 SHALL have ports s_PRDATA_o/s_PREADY_o/s_PSLVERR_o, outputs, DATA/1/1, upstream APB response.
REQ-009 SHALL have ports m_PADDR_o/m_PWDATA_o/m_PWRITE_o/m_PSEL_o/m_PENABLE_o, outputs, ADDR/DATA/1/1/1, downstream APB request to the target slave.
REQ-010 SHALL have ports m_PRDATA_i/m_PREADY_i/m_PSLVERR_i, inputs, DATA/1/1, downstream APB response.
REQ-011 SHALL have port timeout_irq_o, output, 1, one-cycle pulse per abort.
REQ-012 SHALL have ports err_addr_o (ADDR) and err_cnt_o (8), outputs, last aborted address and abort count.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DRAIN.
REQ-014 IDLE/ACCESS: m_* request outputs SHALL equal s_* request inputs combinationally; s_PRDATA_o/s_PREADY_o/s_PSLVERR_o SHALL equal m_* responses combinationally (zero added latency).
REQ-015 IDLE -> ACCESS when s_PSEL_i & s_PENABLE_i & !m_PREADY_i; cycle counter loads 1.
REQ-016 ACCESS: counter increments each cycle without m_PREADY_i; m_PREADY_i=1 -> IDLE, counter cleared.
REQ-017 Abort: in the cycle where counter == TIMEOUT_CYCLES and m_PREADY_i=0, SHALL drive s_PREADY_o=1, s_PSLVERR_o=1, s_PRDATA_o=ERR_RDATA, pulse timeout_irq_o, latch PADDR/PWDATA/PWRITE, go to DRAIN.
REQ-018 Same-cycle m_PREADY_i and expiry: real slave response SHALL win; no abort, no irq.
REQ-019 DRAIN: m_PSEL_o=m_PENABLE_o=1 with latched PADDR/PWDATA/PWRITE, independent of s_*; downstream response discarded.
REQ-020 DRAIN: s_PREADY_o=0, s_PSLVERR_o=0, s_PRDATA_o=0; new upstream transfers stall.
REQ-021 DRAIN -> IDLE on m_PREADY_i=1; next upstream transfer forwarded from following cycle.
REQ-022 Upstream dropping s_PSEL_i in ACCESS (protocol violation) SHALL return to IDLE, counter cleared, no abort.
REQ-023 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); never wraps.
REQ-024 TIMEOUT_CYCLES=1: abort in the first access cycle when m_PREADY_i=0.

Reset
REQ-025 rst=1 at posedge SHALL force IDLE, counter=0, latches=0, timeout_irq_o=0, err_addr_o=0, err_cnt_o=0.
REQ-026 Reset mid-DRAIN SHALL drop m_PSEL_o/m_PENABLE_o to pass-through immediately.
REQ-027 During rst, outputs SHALL follow the IDLE pass-through rule.

Configuration
REQ-028 Macro APB_TIMEOUT_GUARD_STATUS_EN defined: err_addr_o SHALL hold the address latched at the last abort; err_cnt_o SHALL increment per abort, saturating at 255.
REQ-029 Macro undefined: err_addr_o and err_cnt_o SHALL be constant 0 with no status registers; timeout_irq_o and abort behaviour unchanged.

Verification (TIMEOUT_CYCLES=4)
REQ-030 Read 0x100, m_PREADY_i high at access cycle 2, m_PRDATA_i=0x12345678 -> s_PRDATA_o=0x12345678, s_PSLVERR_o=0, no irq.
REQ-031 Write 0x200, m_PREADY_i never high -> access cycle 4: s_PREADY_o=1, s_PSLVERR_o=1, timeout_irq_o one cycle; m_PSEL_o stays 1 with PADDR 0x200.
REQ-032 During DRAIN issue read 0x300 -> s_PREADY_o=0 until m_PREADY_i pulses; 0x300 appears on m_PADDR_o next cycle, completes normally.
REQ-033 m_PREADY_i=1 exactly at access cycle 4 -> normal completion, no irq, err_cnt_o unchanged.
REQ-034 With APB_TIMEOUT_GUARD_STATUS_EN: 257 aborts -> err_cnt_o=255, err_addr_o=last address; rst=1 mid-DRAIN -> next cycle m_PSEL_o=s_PSEL_i, err_cnt_o=0.
